// File: rtl/sonic_v1_15_jtag_master_b2p.sv
`default_nettype none
// ============================================================================
// Module   : sonic_v1_15_jtag_master_b2p
// Brief    : Byte-stream to packet decoder; strips SOP/EOP/channel/escape
//            control characters and emits tagged data beats.
// Revision : 1.0
// ============================================================================
module sonic_v1_15_jtag_master_b2p #(
   parameter int CHANNEL_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data,
   output logic                     out_startofpacket,
   output logic                     out_endofpacket,
   output logic [CHANNEL_WIDTH-1:0] out_channel,
   input  logic                     out_ready
);

   localparam logic [7:0] c_sop     = 8'h7A;
   localparam logic [7:0] c_eop     = 8'h7B;
   localparam logic [7:0] c_chan    = 8'h7C;
   localparam logic [7:0] c_esc     = 8'h7D;
   localparam logic [7:0] c_esc_xor = 8'h20;

   logic                     r_sop_pend;
   logic                     r_eop_pend;
   logic                     r_chan_pend;
   logic                     r_esc_pend;
   logic [CHANNEL_WIDTH-1:0] r_chan_reg;

   logic                     r_out_valid;
   logic [7:0]               r_out_data;
   logic                     r_out_sop;
   logic                     r_out_eop;
   logic [CHANNEL_WIDTH-1:0] r_out_channel;

   logic                     w_in_ready;
   logic                     w_accept;
   logic                     w_emit;
   logic [7:0]               w_value;
   logic                     w_sop_nxt;
   logic                     w_eop_nxt;
   logic                     w_chan_pend_nxt;
   logic                     w_esc_pend_nxt;
   logic [CHANNEL_WIDTH-1:0] w_chan_reg_nxt;

   // The output slot is free when empty or being drained this cycle.
   assign w_in_ready = out_ready | ~r_out_valid;
   assign w_accept   = in_valid & w_in_ready;

   always_comb begin
      w_emit          = 1'b0;
      w_value         = in_data;
      w_sop_nxt       = r_sop_pend;
      w_eop_nxt       = r_eop_pend;
      w_chan_pend_nxt = r_chan_pend;
      w_esc_pend_nxt  = r_esc_pend;
      w_chan_reg_nxt  = r_chan_reg;

      if (w_accept) begin
         if (r_esc_pend) begin
            w_value        = in_data ^ c_esc_xor;
            w_esc_pend_nxt = 1'b0;
            if (r_chan_pend) begin
               w_chan_reg_nxt  = w_value[CHANNEL_WIDTH-1:0];
               w_chan_pend_nxt = 1'b0;
            end else begin
               w_emit = 1'b1;
            end
         end else begin
            case (in_data)
               c_sop: begin
                  w_sop_nxt       = 1'b1;
                  w_chan_pend_nxt = 1'b0;
               end
               c_eop: begin
                  w_eop_nxt       = 1'b1;
                  w_chan_pend_nxt = 1'b0;
               end
               c_chan: begin
                  w_chan_pend_nxt = 1'b1;
               end
               c_esc: begin
                  // A pending channel selection survives the escape so the
                  // escaped byte can become the channel value.
                  w_esc_pend_nxt = 1'b1;
               end
               default: begin
                  if (r_chan_pend) begin
                     w_chan_reg_nxt  = in_data[CHANNEL_WIDTH-1:0];
                     w_chan_pend_nxt = 1'b0;
                  end else begin
                     w_emit = 1'b1;
                  end
               end
            endcase
         end

         if (w_emit) begin
            w_sop_nxt = 1'b0;
            w_eop_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sop_pend    <= 1'b0;
         r_eop_pend    <= 1'b0;
         r_chan_pend   <= 1'b0;
         r_esc_pend    <= 1'b0;
         r_chan_reg    <= '0;
         r_out_valid   <= 1'b0;
         r_out_data    <= 8'h00;
         r_out_sop     <= 1'b0;
         r_out_eop     <= 1'b0;
         r_out_channel <= '0;
      end else begin
         r_sop_pend  <= w_sop_nxt;
         r_eop_pend  <= w_eop_nxt;
         r_chan_pend <= w_chan_pend_nxt;
         r_esc_pend  <= w_esc_pend_nxt;
         r_chan_reg  <= w_chan_reg_nxt;

         if (w_emit) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_value;
            r_out_sop     <= r_sop_pend;
            r_out_eop     <= r_eop_pend;
            r_out_channel <= r_chan_reg;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready          = w_in_ready;
   assign out_valid         = r_out_valid;
   assign out_data          = r_out_data;
   assign out_startofpacket = r_out_sop;
   assign out_endofpacket   = r_out_eop;
   assign out_channel       = r_out_channel;

endmodule
`default_nettype wire

// File: tb/tb_sonic_v1_15_jtag_master_b2p.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonic_v1_15_jtag_master_b2p
// Brief    : Scoreboard bench for the byte-to-packet decoder (CHANNEL_WIDTH=4).
// Revision : 1.0
// ============================================================================
module tb_sonic_v1_15_jtag_master_b2p;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_ready;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_startofpacket;
   logic          out_endofpacket;
   logic [CW-1:0] out_channel;
   logic          out_ready = 1'b1;

   sonic_v1_15_jtag_master_b2p #(.CHANNEL_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data),
      .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
      .out_channel(out_channel), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]    data;
      logic          sop;
      logic          eop;
      logic [CW-1:0] ch;
   } beat_t;

   beat_t exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

   // Reference model state, owned by the monitor process.
   bit            m_sop, m_eop, m_chp, m_esc;
   logic [CW-1:0] m_chan;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_byte(input logic [7:0] b, output bit emit);
      logic [7:0] v;
      emit = 0;
      v = b;
      if (m_esc) begin
         m_esc = 0;
         v = b ^ 8'h20;
         if (m_chp) begin m_chan = v[CW-1:0]; m_chp = 0; end
         else emit = 1;
      end else if (b == 8'h7A) begin m_sop = 1; m_chp = 0; end
      else if (b == 8'h7B) begin m_eop = 1; m_chp = 0; end
      else if (b == 8'h7C) m_chp = 1;
      else if (b == 8'h7D) m_esc = 1;
      else if (m_chp) begin m_chan = b[CW-1:0]; m_chp = 0; end
      else emit = 1;
      if (emit) begin
         exp_q.push_back('{data: v, sop: m_sop, eop: m_eop, ch: m_chan});
         m_sop = 0;
         m_eop = 0;
      end
   endtask

   // Monitor: latency, handshake, hold stability and beat content.
   bit          exp_known = 0;
   bit          exp_v;
   bit          hold_prev = 0;
   logic [14:0] held;
   always @(negedge clk) begin
      bit    emit;
      beat_t got, want;
      if (!reset_n) begin
         m_sop = 0; m_eop = 0; m_chp = 0; m_esc = 0; m_chan = '0;
         exp_q.delete();
         exp_known = 0;
         hold_prev = 0;
      end else begin
         got = '{data: out_data, sop: out_startofpacket, eop: out_endofpacket, ch: out_channel};
         if (exp_known) chk("out_valid_timing", {31'd0, out_valid}, {31'd0, exp_v});
         chk("in_ready_rule", {31'd0, in_ready}, {31'd0, out_ready | ~out_valid});
         if (hold_prev)
            chk("hold_stable", {17'd0, out_valid, got}, {17'd0, held});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {16'd0, got}, 32'hFFFF_FFFF);
            end else begin
               want = exp_q.pop_front();
               chk("beat", {16'd0, got}, {16'd0, want});
            end
         end
         emit = 0;
         if (in_valid && in_ready) model_byte(in_data, emit);
         exp_v     = emit || (out_valid && !out_ready);
         exp_known = 1;
         hold_prev = out_valid && !out_ready;
         held      = {out_valid, got};
      end
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 9) < 7);
         default: out_ready = 1'b0;
      endcase
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_seq(input logic [7:0] s[]);
      foreach (s[i]) send_byte(s[i]);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_sop_eop", {30'd0, out_startofpacket, out_endofpacket}, 32'd0);
      chk("rst_channel", {28'd0, out_channel}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] b;
      do_reset();

      send_seq('{8'h7A, 8'h7C, 8'h05, 8'h11, 8'h22, 8'h7B, 8'h33});
      send_seq('{8'h7A, 8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7B, 8'h7D, 8'h5C});
      send_seq('{8'h7C, 8'h7D, 8'h5B, 8'h44, 8'h7C, 8'hFF, 8'h55});
      idle(3);

      // Stall the output behind the first beat while a byte waits upstream.
      rdy_mode  = 2;
      out_ready = 1'b0;
      send_seq('{8'h7A, 8'h11});
      in_valid = 1'b1;
      in_data  = 8'h22;
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_data", {24'd0, out_data}, 32'h11);
      end
      rdy_mode  = 0;
      out_ready = 1'b1;
      send_seq('{8'h22, 8'h7B, 8'h33});
      send_seq('{8'h7A, 8'h7B, 8'h99, 8'h7C, 8'h7A, 8'h66});
      idle(2);

      send_seq('{8'h7A, 8'h7D});
      do_reset();
      send_byte(8'h41);
      idle(3);

      rdy_mode = 1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) < 4) b = 8'h7A + 8'($urandom_range(0, 3));
         else b = 8'($urandom);
         send_byte(b);
         if ($urandom_range(0, 15) == 0) idle(1);
      end

      rdy_mode = 0;
      idle(1);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sonic_v1_15_jtag_master_b2p.md
Name: sonic_v1_15_jtag_master_b2p

Overview:
- Byte-stream-to-packet decoder in the JTAG master datapath.
- Consumes the raw 8-bit Avalon-ST byte stream produced by the JTAG master timing adapter (via the byte FIFO).
- Strips in-band control characters and emits 8-bit data beats tagged with start-of-packet, end-of-packet and channel to the packets-to-transactions stage.
- Single registered output stage with full ready/valid backpressure.

Parameters:
CHANNEL_WIDTH, 8, width of out_channel; legal 1..8; channel byte truncated to its low CHANNEL_WIDTH bits.

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
in_valid  input  1  upstream byte valid
in_data  input  8  upstream byte
in_ready  output  1  block accepts a byte this cycle
out_valid  output  1  output beat valid
out_data  output  8  decoded data byte
out_startofpacket  output  1  beat is first of packet
out_endofpacket  output  1  beat is last of packet
out_channel  output  CHANNEL_WIDTH  channel of beat
out_ready  input  1  downstream accepts beat

Behaviour:
- One clock (clk); reset_n is synchronous, active-low, sampled on rising clk edge.
- Control characters: 0x7A SOP marker, 0x7B EOP marker, 0x7C channel marker, 0x7D escape.
- Internal flags: sop_pend, eop_pend, chan_pend, esc_pend; register chan_reg.
- Reset: out_valid=0, out_data=0x00, out_startofpacket=0, out_endofpacket=0, out_channel=0, all flags 0, chan_reg=0.
  - Applies mid-packet too: partial packet state discarded; any pending beat dropped.
- in_ready = out_ready | ~out_valid (combinational); equals 1 immediately after reset.
- Accept = in_valid & in_ready. No state changes without accept.
- On accept, with esc_pend=0:
  - 0x7A: sop_pend<=1.
  - 0x7B: eop_pend<=1.
  - 0x7C: chan_pend<=1.
  - 0x7D: esc_pend<=1.
  - 0x7A/0x7B/0x7C arriving while chan_pend=1 also clear chan_pend, then apply their own effect (0x7C re-arms it).
  - 0x7D while chan_pend=1 keeps chan_pend.
  - Other byte b: if chan_pend, chan_reg<=b[CHANNEL_WIDTH-1:0] and chan_pend<=0, no beat emitted. Otherwise emit a data beat with value b.
- On accept, with esc_pend=1: byte b is never a control char. Value v=b^0x20; esc_pend<=0. If chan_pend, v loads chan_reg. Otherwise emit a data beat with value v.
- Data beat emission (registered, latency 1 cycle from accept):
  - out_valid<=1, out_data<=value.
  - out_startofpacket<=sop_pend, out_endofpacket<=eop_pend.
  - out_channel<=chan_reg, including a chan_reg update made earlier in the same byte sequence.
  - sop_pend<=0, eop_pend<=0.
- Markers are sticky until consumed by a data beat; repeated markers are idempotent.
- Channel persists across packets until rewritten.
- Output hold: while out_valid=1 & out_ready=0, all out_* signals stable and in_ready=0.
- Output clear: out_valid=1 & out_ready=1 with no new beat that cycle: out_valid<=0 (other out_* may hold).
- Simultaneous output drain and input data byte: new beat loaded the same cycle. Full throughput is 1 beat/cycle.
- Escape and marker bytes consume a cycle but produce no beat; no bubble is required between them and data.

Test Plan:
- Reset then feed 7A 7C 05 11 22 7B 33, out_ready=1 -> beats 11(sop=1,ch=5), 22(ch=5), 33(eop=1,ch=5). Each beat appears 1 cycle after its byte is accepted; no beats for 7A/7C/05/7B.
- Escapes: 7A 7D 5A 7D 5D 7B 7D 5C -> beats 7A(sop), 7D, 7C(eop); escaped 7D 5C loads no channel.
- Channel via escape and truncation with CHANNEL_WIDTH=4: 7C 7D 5B 44 -> beat 44 on ch=0xB. Then 7C FF 55 -> beat 55 on ch=0xF.
- Backpressure: hold out_ready=0 after first beat while in_valid=1 -> in_ready=0, out_* stable 5 cycles. Release -> remaining beats in order, none lost or duplicated.
- Single-byte packet 7A 7B 99 -> one beat 99 with sop=1 and eop=1. Then 7C 7A 66 -> chan_pend cancelled, beat 66 sop=1, channel unchanged.
- Reset mid-packet after 7A 7D -> outputs zero. Next byte 41 -> beat 41 with sop=0, not treated as escaped (not 61).
